// File: rtl/dcpu16_pkg.sv
// dcpu16_pkg: shared constants and types for the dcpu16 sequencer.
//   Default field geometry of the instruction word, the NOP encoding,
//   opcode ranges, the "destination is PC" operand code and the phase enum.
package dcpu16_pkg;

   // Default instruction word geometry: [B:FLD][A:FLD][OP:OPW]
   localparam int unsigned OPW_D = 4;
   localparam int unsigned FLD_D = 6;
   localparam int unsigned DW_D  = OPW_D + 2 * FLD_D;
   localparam int unsigned RAW_D = 3;

   // Field slice positions (LSB of each field)
   localparam int unsigned OP_LSB = 0;
   localparam int unsigned A_LSB  = OPW_D;
   localparam int unsigned B_LSB  = OPW_D + FLD_D;

   // Opcodes
   localparam logic [OPW_D-1:0] OP_EXT    = 4'h0;
   localparam logic [OPW_D-1:0] OP_SET    = 4'h1;
   localparam logic [OPW_D-1:0] OP_IFBASE = 4'hC;

   // SET A,A: opcode SET with both operands zero
   localparam logic [DW_D-1:0] NOP = 16'h0001;

   // Operand-A code selecting PC as destination
   localparam logic [FLD_D-1:0] PCSEL_D = 6'h1C;

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_e;

endpackage

// File: rtl/dcpu16_seq_if.sv
// dcpu16_seq_if: instruction fetch bus between sequencer and memory.
//   f_dti : fetch read data (memory -> sequencer)
//   f_ack : fetch acknowledge, f_dti valid when high
//   f_stb : fetch request (sequencer -> memory)
interface dcpu16_seq_if #(
   parameter int unsigned DW = 16
);
   logic [DW-1:0] f_dti;
   logic          f_ack;
   logic          f_stb;

   modport master (output f_stb, input f_dti, input f_ack);
   modport slave  (input f_stb, output f_dti, output f_ack);
endinterface

// File: rtl/dcpu16_seq_phase.sv
// dcpu16_seq_phase: four-phase cycle counter with fetch stall.
//   clk, rst : clock, synchronous active-high reset
//   ena      : clock enable, low holds the phase
//   f_ack    : fetch acknowledge
//   pha      : current phase
//   f_stb    : fetch request, high throughout phase 2
//   adv      : phase advances this cycle (enabled and not stalled)
//   acc      : fetch word accepted this cycle
module dcpu16_seq_phase
   import dcpu16_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   ena,
   input  logic   f_ack,
   output phase_e pha,
   output logic   f_stb,
   output logic   adv,
   output logic   acc
);

   phase_e pha_q, pha_d;
   logic   stall;

   always_comb begin
      stall = (pha_q == PH2) && !f_ack;
      adv   = ena && !stall;
      acc   = ena && (pha_q == PH2) && f_ack;
      pha_d = pha_q;
      if (adv) begin
         pha_d = phase_e'(pha_q + 2'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pha_q <= PH0;
      end else begin
         pha_q <= pha_d;
      end
   end

   assign pha   = pha_q;
   assign f_stb = (pha_q == PH2);

endmodule

// File: rtl/dcpu16_seq.sv
// dcpu16_seq: four-phase instruction sequencer with fetch wait states and
// conditional skip of the instruction following a failed IF-class test.
//   clk, rst : clock, synchronous active-high reset
//   ena      : clock enable; low holds everything, rwe forced low
//   fb       : fetch bus (f_dti, f_ack in; f_stb out)
//   CC       : condition result for the instruction in execute
//   wpc      : datapath wrote PC; the word being fetched is squashed
//   ireg     : latched instruction word
//   pha      : current phase 0..3
//   opc      : opcode of the instruction in execute
//   rra      : register read address (B in phases 0/2, A in phases 1/3)
//   rwa, rwe : register write address / single-cycle write enable
//   bra      : instruction in execute targets PC
//   skp      : instruction in execute is being skipped
module dcpu16_seq
   import dcpu16_pkg::*;
#(
   parameter int unsigned      DW     = DW_D,
   parameter int unsigned      OPW    = OPW_D,
   parameter int unsigned      FLD    = FLD_D,
   parameter int unsigned      RAW    = RAW_D,
   parameter logic [OPW-1:0]   IFBASE = OP_IFBASE,
   parameter logic [FLD-1:0]   PCSEL  = PCSEL_D
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ena,
   dcpu16_seq_if.master   fb,
   input  logic           CC,
   input  logic           wpc,
   output logic [DW-1:0]  ireg,
   output logic [1:0]     pha,
   output logic [OPW-1:0] opc,
   output logic [RAW-1:0] rra,
   output logic [RAW-1:0] rwa,
   output logic           rwe,
   output logic           bra,
   output logic           skp
);

   localparam logic [DW-1:0] NOP_W = DW'(1);

   phase_e pha_s;
   logic   adv, acc, f_stb_s;

   logic [DW-1:0]  ireg_q, ireg_d;
   logic [OPW-1:0] opc_q, opc_d;
   logic [FLD-1:0] xa_q, xa_d;
   logic           bra_q, bra_d;
   logic           skp_q, skp_d;
   logic [RAW-1:0] rra_q, rra_d;
   logic [RAW-1:0] rwa_q, rwa_d;
   logic           rwe_q, rwe_d;
   logic           skip_next;
   logic [FLD-1:0] a_fld;

   dcpu16_seq_phase u_phase (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .f_ack (fb.f_ack),
      .pha   (pha_s),
      .f_stb (f_stb_s),
      .adv   (adv),
      .acc   (acc)
   );

   always_comb begin
      ireg_d = ireg_q;
      opc_d  = opc_q;
      xa_d   = xa_q;
      bra_d  = bra_q;
      skp_d  = skp_q;
      rra_d  = rra_q;
      rwa_d  = rwa_q;
      rwe_d  = 1'b0;

      a_fld     = ireg_q[OPW +: FLD];
      // Decided on the instruction still in execute, before it is replaced
      skip_next = (opc_q >= IFBASE) && !CC;

      if (adv) begin
         if (pha_s == PH0 || pha_s == PH2) begin
            rra_d = ireg_q[OPW + FLD +: RAW];
         end else begin
            rra_d = ireg_q[OPW +: RAW];
         end
         if (pha_s == PH0) begin
            rwa_d = xa_q[RAW-1:0];
            rwe_d = (xa_q[FLD-1:RAW] == '0) && (opc_q != '0) &&
                    (opc_q < IFBASE) && CC && !skp_q;
         end
      end

      // The squashed word becomes NOP, which can never arm a further skip
      if (acc) begin
         ireg_d = (wpc || skip_next) ? NOP_W : fb.f_dti;
         opc_d  = ireg_q[OPW-1:0];
         xa_d   = a_fld;
         bra_d  = (a_fld == PCSEL);
         skp_d  = skip_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ireg_q <= NOP_W;
         opc_q  <= '0;
         xa_q   <= '0;
         bra_q  <= 1'b0;
         skp_q  <= 1'b0;
         rra_q  <= '0;
         rwa_q  <= '0;
         rwe_q  <= 1'b0;
      end else begin
         ireg_q <= ireg_d;
         opc_q  <= opc_d;
         xa_q   <= xa_d;
         bra_q  <= bra_d;
         skp_q  <= skp_d;
         rra_q  <= rra_d;
         rwa_q  <= rwa_d;
         rwe_q  <= rwe_d;
      end
   end

   assign fb.f_stb = f_stb_s;
   assign ireg     = ireg_q;
   assign pha      = pha_s;
   assign opc      = opc_q;
   assign rra      = rra_q;
   assign rwa      = rwa_q;
   assign rwe      = rwe_q;
   assign bra      = bra_q;
   assign skp      = skp_q;

endmodule

// File: doc/dcpu16_seq.md
Name: dcpu16_seq

Overview:
- Parametrised successor to the dcpu16 four-phase control unit.
- Sequences a 4-phase instruction cycle, latches fetched instruction words and drives register-file read/write addressing.
- Adds two things the fixed 16-bit controller lacks: a fetch wait-state handshake (`f_stb`/`f_ack` stall), and conditional-skip handling for IF-class opcodes.
- Sits between the fetch bus and the datapath/register file; the datapath returns CC and wpc.

Parameters:
- DW, 16, instruction word width; must equal OPW + 2*FLD.
- OPW, 4, opcode field width (bits [OPW-1:0]).
- FLD, 6, operand field width; A = bits [OPW+FLD-1:OPW], B = bits [DW-1:OPW+FLD].
- RAW, 3, register address width (RAW < FLD).
- IFBASE, 4'hC, lowest conditional (IF-class) opcode; opcodes >= IFBASE are conditional.
- PCSEL, 6'h1C, operand-A code meaning "destination is PC".

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ena  in  1  global clock enable; low = hold all state
- f_dti  in  DW  fetch read data
- f_ack  in  1  fetch acknowledge; f_dti valid when high
- f_stb  out  1  fetch request
- CC  in  1  condition result from datapath for instruction in execute
- wpc  in  1  datapath wrote PC; squash the word being fetched
- ireg  out  DW  latched instruction
- pha  out  2  current phase 0..3
- opc  out  OPW  opcode of instruction in execute
- rra  out  RAW  register read address
- rwa  out  RAW  register write address
- rwe  out  1  register write enable, single-cycle pulse
- bra  out  1  instruction in execute targets PC
- skp  out  1  instruction in execute is being skipped

Behaviour:
- Reset (rst high at clk edge, regardless of ena):
  - pha=0, ireg=NOP (value 1: SET A,A), opc=0, xa=0, bra=0, skp=0.
  - rra=0, rwa=0, rwe=0.
  - Reset mid-stall abandons the fetch; `f_stb` drops the next cycle.
- ena low: every register holds, except rwe, which is forced to 0 (no repeated writes).
- Phase counter: when ena is high and not stalled, pha advances 0->1->2->3->0 (2-bit wrap).
- f_stb = (pha==2), decoded from the pha register.
- Stall condition: pha==2 and f_ack low.
  - pha, ireg, opc, xa, bra, skp and rra all hold; rwe=0.
  - Unlimited wait states.
- Accept event: pha==2, f_ack high, ena high. On accept:
  - ireg <= NOP if (wpc | skip_next), else f_dti.
  - opc <= old ireg[OPW-1:0]; xa <= old ireg A field.
  - bra <= (old ireg A field == PCSEL).
  - skp <= skip_next, where skip_next = (opc >= IFBASE) & !CC, evaluated on the current (pre-accept) opc.
- Skip chaining: a squashed word becomes NOP, which never sets a new skip. wpc and skip on the same accept produce a single NOP, no double effect.
- Read address, registered and updated every enabled, non-stalled cycle:
  - rra <= B[RAW-1:0] when pha==0 or 2.
  - rra <= A[RAW-1:0] when pha==1 or 3.
  - Both fields are taken from ireg.
- Write control, at pha==0 (enabled):
  - rwa <= xa[RAW-1:0].
  - rwe <= (xa[FLD-1:RAW]==0) & (opc!=0) & (opc<IFBASE) & CC & !skp.
- rwe timing and targets:
  - rwe is high only in the cycle where pha==1, and cleared in every other phase.
  - rwa holds until the next pha==0.
  - Non-register destinations (upper field bits nonzero), extended opcode 0, IF-class ops and skipped instructions never write.
- Latency: fetched word appears in ireg the cycle after accept; its write pulse occurs 3 phases after the next accept (one instruction of pipeline).

Decomposition:
- Shared package dcpu16_pkg holds:
  - Field-slice constants for the opcode and A/B operand fields.
  - NOP constant.
  - Opcode localparams (SET=1, IFBASE range).
  - PCSEL code.
  - Phase enum PH0..PH3.
- One natural sub-module: dcpu16_seq_phase.
  - Contains the phase counter plus stall/f_stb logic.
  - Outputs pha and an accept strobe.
- The rest of the block stays flat.

Test Plan:
- Reset then ena=1, f_ack tied high, f_dti=16'h0401 (SET A,B: A=0, B=1).
  - pha cycles 0,1,2,3.
  - ireg=16'h0401 after the first accept.
  - One instruction later: rwe pulses exactly one cycle at pha==1 with rwa=0; rra alternates 1/0.
- Hold f_ack low for 5 cycles at pha==2.
  - pha stays 2 and f_stb stays high for 6 cycles; rwe=0.
  - Advances on the f_ack=1 cycle; ireg = f_dti captured that cycle.
- Execute IFE (opc=4'hC) with CC=0.
  - Next fetched word 16'h0401 is replaced by 16'h0001; skp=1.
  - No rwe for it.
  - With CC=1 instead: word kept, skp=0.
- wpc=1 during accept of 16'h0401.
  - ireg=16'h0001; no write to A.
- Instruction with A=PCSEL (16'h01C1).
  - bra=1 after the following accept; rwe stays 0 (upper field nonzero).
- Assert rst during a pha==2 stall, then with ena=0 for 3 cycles.
  - All outputs are at reset values; ireg=16'h0001; pha frozen at 0 while ena=0.
